param_fifo: RTL and testbench
=============================

// Module: param_fifo
// PURPOSE
//  Parametrised synchronous FIFO; next generation of the 8x3 queue. Generic WIDTH/DEPTH,
//  a real registered read path and a fill-level count. Adds almost-full/almost-empty
//  thresholds, overflow/underflow error pulses and defined simultaneous read/write
//  behaviour. Sits between producer and consumer blocks in the same clock domain.
// PARAMETERS
//  WIDTH       3   data bits per entry
//  ADDR_W      3   log2(depth); DEPTH = 2**ADDR_W (default 8 entries)
//  AFULL_LVL   6   almost_full asserted when count >= AFULL_LVL
//  AEMPTY_LVL  2   almost_empty asserted when count <= AEMPTY_LVL
// PORTS
//  clk           in   1         single clock, rising edge
//  reset         in   1         asynchronous, active-low; 0 = reset
//  wr_signal     in   1         write request; din captured when accepted
//  din           in   WIDTH     write data
//  rd_signal     in   1         read request
//  dout          out  WIDTH     read data, registered
//  dout_valid    out  1         1-cycle pulse: dout holds newly read entry
//  empty         out  1         count == 0
//  full          out  1         count == DEPTH
//  almost_full   out  1         count >= AFULL_LVL
//  almost_empty  out  1         count <= AEMPTY_LVL
//  count         out  ADDR_W+1  entries stored, 0..DEPTH
//  overflow      out  1         1-cycle pulse: write rejected (full)
//  underflow     out  1         1-cycle pulse: read rejected (empty)
// BEHAVIOUR
//  - Reset (reset==0, async): wr/rd ptrs=0, count=0, dout=0, dout_valid=0, empty=1,
//    full=0, almost_empty=1, almost_full=0, overflow=underflow=0; storage cleared to 0.
//    Reset mid-operation discards all contents; no partial write survives.
//  - Pointers ADDR_W+1 bits; low ADDR_W bits index storage, MSB is wrap bit. Increment
//    modulo 2**(ADDR_W+1); entry DEPTH-1 wraps to entry 0.
//  - wr_acc = wr_signal & (~full | rd_signal); rd_acc = rd_signal & ~empty.
//  - wr_acc: mem[wr_ptr] <= din, wr_ptr+1. rd_acc: dout <= mem[rd_ptr], rd_ptr+1,
//    dout_valid=1 next cycle. Read latency: 1 clk from rd_signal to dout/dout_valid.
//  - dout holds last read value when no read accepted; never changes on write alone.
//  - Full + wr + rd same cycle: both accepted, count stays DEPTH, write uses freed slot.
//  - Empty + wr + rd same cycle: write accepted, read rejected, underflow=1, count->1.
//    No write-through bypass: the new entry is readable from the following cycle.
//  - Not full/empty + wr + rd: both accepted, count unchanged.
//  - overflow = wr_signal & ~wr_acc; underflow = rd_signal & ~rd_acc; registered,
//    one-cycle pulses; FIFO state unchanged by rejected requests.
//  - count += wr_acc - rd_acc; all status flags registered, derived from next count,
//    valid in the same cycle as count.
//  - No X: undriven storage never reaches dout (storage reset).
// STRUCTURE
//  - Shared package fifo_pkg: default WIDTH/ADDR_W, localparam DEPTH = 1<<ADDR_W,
//    ptr width ADDR_W+1.
//  - Sub-module fifo_ptr (parametrised successor of ptr_reg): ADDR_W+1 bit counter,
//    ports clk, reset, inc, ptr; instantiated twice (write, read).
//  - Storage: register array DEPTH x WIDTH inside param_fifo; write decode from
//    wr_ptr[ADDR_W-1:0], read mux from rd_ptr[ADDR_W-1:0] into dout register.
// TESTING (defaults WIDTH=3, ADDR_W=3)
//  1 Reset: reset=0 mid-stream with 5 entries -> count=0, empty=1, dout=0; reset=1,
//    read -> underflow=1, dout stays 0.
//  2 Fill: write 1..7,0 (8 writes) -> full=1, count=8, almost_full from 6th write;
//    9th write -> overflow=1, count stays 8.
//  3 Drain: 8 reads -> dout 1,2,..7,0 each 1 clk after rd_signal, dout_valid each;
//    empty=1 after last; almost_empty at count<=2.
//  4 Wrap: write 4, read 4, write 8 (5,6,7,1,2,3,4,5), read 8 -> same order, ptr
//    wrap bit toggled, full seen with ptr low bits equal.
//  5 Simultaneous: at full, wr=rd=1 din=6 -> no overflow, count 8, 6 read last;
//    at empty, wr=rd=1 din=2 -> underflow=1, count=1, next read returns 2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the parametrised FIFO family: entry width, address width,
// derived depth/pointer width and the default almost-full/almost-empty thresholds.
package fifo_pkg;

  localparam int DEF_WIDTH      = 3;
  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_W;
  localparam int DEF_PTR_W      = DEF_ADDR_W + 1;
  localparam int DEF_AFULL_LVL  = 6;
  localparam int DEF_AEMPTY_LVL = 2;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// FIFO pointer: ADDR_W+1 bit wrapping counter; low bits address storage, MSB is the
// wrap bit that tells full from empty when the low bits match.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [ADDR_W:0] ptr
);

  localparam int PTR_W = ADDR_W + 1;

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule : fifo_ptr

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with registered read data, fill count, almost-full/
// almost-empty thresholds and overflow/underflow pulses.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int AFULL_LVL  = DEF_AFULL_LVL,
  parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_signal,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_signal,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR_W:0]  count,
  output logic             overflow,
  output logic             underflow
);

  localparam int               DEPTH    = 1 << ADDR_W;
  localparam int               PTR_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0]  DEPTH_C  = PTR_W'(DEPTH);
  localparam logic [ADDR_W:0]  AFULL_C  = PTR_W'(AFULL_LVL);
  localparam logic [ADDR_W:0]  AEMPTY_C = PTR_W'(AEMPTY_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [ADDR_W:0]  wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             wr_acc, rd_acc;

  // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
  assign wr_acc = wr_signal & (~full | rd_signal);
  assign rd_acc = rd_signal & ~empty;

  // Fill level is the modular distance between the post-edge pointers, which equals
  // count + wr_acc - rd_acc and stays in 0..DEPTH.
  assign wr_ptr_nxt = wr_ptr + PTR_W'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(rd_acc);
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // NOTE: storage is reset on purpose so no unwritten (X) entry can ever reach dout;
  // this costs a reset net per storage flop instead of a plain RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  // On full+wr+rd the read slot equals the write slot; the read sees the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout         <= '0;
      dout_valid   <= 1'b0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (rd_acc) dout <= mem[rd_ptr[ADDR_W-1:0]];
      dout_valid   <= rd_acc;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      overflow     <= wr_signal & ~wr_acc;
      underflow    <= rd_signal & ~rd_acc;
    end
  end

endmodule : param_fifo

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at default parameters (WIDTH=3, ADDR_W=3, 8 entries).
`timescale 1ns/1ps
module tb_param_fifo;

  logic       clk;
  logic       reset;
  logic       wr_signal;
  logic [2:0] din;
  logic       rd_signal;
  logic [2:0] dout;
  logic       dout_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  param_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr_signal    (wr_signal),
    .din          (din),
    .rd_signal    (rd_signal),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {count, full, empty, almost_full, almost_empty} for a fill level n.
  function automatic logic [7:0] exp_status(input int n);
    logic [3:0] c;
    c = 4'(n);
    return {c, (n == 8), (n == 0), (n >= 6), (n <= 2)};
  endfunction

  function automatic logic [7:0] act_status();
    return {count, full, empty, almost_full, almost_empty};
  endfunction

  // One clock with the given requests; outputs are sampled 1 ns after the edge.
  task automatic cycle(input logic wr, input logic [2:0] d, input logic rd);
    wr_signal = wr;
    din       = d;
    rd_signal = rd;
    @(posedge clk);
    #1;
    wr_signal = 1'b0;
    rd_signal = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (act_status() !== exp_status(0) || {dout, dout_valid, overflow, underflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_init status=%b dout=%0d dv=%b ov=%b un=%b required status=%b zeros",
               act_status(), dout, dout_valid, overflow, underflow, exp_status(0));
    end
    for (int i = 1; i <= 6; i++) cycle(1'b1, 3'(i), 1'b0);
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (dout !== 3'd1 || act_status() !== exp_status(5)) begin
      errors++;
      $display("FAIL reset_prefill dout=%0d status=%b required dout=1 status=%b",
               dout, act_status(), exp_status(5));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (act_status() !== exp_status(0) || dout !== 3'd0 || dout_valid !== 1'b0 ||
        dut.wr_ptr !== 4'd0 || dut.rd_ptr !== 4'd0) begin
      errors++;
      $display("FAIL reset_async status=%b dout=%0d dv=%b wr_ptr=%0d rd_ptr=%0d required status=%b dout=0 ptrs=0",
               act_status(), dout, dout_valid, dut.wr_ptr, dut.rd_ptr, exp_status(0));
    end
    @(negedge clk) reset = 1'b1;
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (underflow !== 1'b1 || dout !== 3'd0 || dout_valid !== 1'b0 || act_status() !== exp_status(0)) begin
      errors++;
      $display("FAIL reset_underflow un=%b dout=%0d dv=%b status=%b required un=1 dout=0 dv=0 status=%b",
               underflow, dout, dout_valid, act_status(), exp_status(0));
    end
    cycle(1'b0, 3'd0, 1'b0);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_underflow_pulse un=%b required 0", underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'(i + 1), 1'b0);
      checks++;
      if (act_status() !== exp_status(i + 1) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d status=%b ov=%b required status=%b ov=0",
                 i + 1, act_status(), overflow, exp_status(i + 1));
      end
    end
    cycle(1'b1, 3'd5, 1'b0);
    checks++;
    if (overflow !== 1'b1 || act_status() !== exp_status(8)) begin
      errors++;
      $display("FAIL fill_overflow ov=%b status=%b required ov=1 status=%b",
               overflow, act_status(), exp_status(8));
    end
    cycle(1'b0, 3'd0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_overflow_pulse ov=%b required 0", overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 1'b1);
      checks++;
      if (dout !== 3'(i + 1) || dout_valid !== 1'b1 || act_status() !== exp_status(7 - i)) begin
        errors++;
        $display("FAIL drain_%0d dout=%0d dv=%b status=%b required dout=%0d dv=1 status=%b",
                 i, dout, dout_valid, act_status(), 3'(i + 1), exp_status(7 - i));
      end
    end
    cycle(1'b0, 3'd0, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || dout !== 3'd0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle dv=%b dout=%0d un=%b required dv=0 dout=0 un=0",
               dout_valid, dout, underflow);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] vals [8];
    vals = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    checks++;
    if (dut.wr_ptr !== 4'd8 || dut.rd_ptr !== 4'd8) begin
      errors++;
      $display("FAIL wrap_ptr_start wr_ptr=%0d rd_ptr=%0d required 8 8", dut.wr_ptr, dut.rd_ptr);
    end
    for (int i = 1; i <= 4; i++) cycle(1'b1, 3'(i), 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 3'd0, 1'b1);
      checks++;
      if (dout !== 3'(i) || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_first_%0d dout=%0d dv=%b required dout=%0d dv=1", i, dout, dout_valid, i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vals[i], 1'b0);
      if (i == 0) begin
        checks++;
        if (dout !== 3'd4 || dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL wrap_dout_hold dout=%0d dv=%b required dout=4 dv=0", dout, dout_valid);
        end
      end
    end
    checks++;
    if (act_status() !== exp_status(8) || dut.wr_ptr !== 4'd4 || dut.rd_ptr !== 4'd12) begin
      errors++;
      $display("FAIL wrap_full status=%b wr_ptr=%0d rd_ptr=%0d required status=%b wr_ptr=4 rd_ptr=12",
               act_status(), dut.wr_ptr, dut.rd_ptr, exp_status(8));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 1'b1);
      checks++;
      if (dout !== vals[i] || dout_valid !== 1'b1 || act_status() !== exp_status(7 - i)) begin
        errors++;
        $display("FAIL wrap_read_%0d dout=%0d dv=%b status=%b required dout=%0d dv=1 status=%b",
                 i, dout, dout_valid, act_status(), vals[i], exp_status(7 - i));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_rd [8];
    exp_rd = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd6};
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i + 1), 1'b0);
    cycle(1'b1, 3'd6, 1'b1);
    checks++;
    if (overflow !== 1'b0 || act_status() !== exp_status(8) || dout !== 3'd1 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_full ov=%b status=%b dout=%0d dv=%b required ov=0 status=%b dout=1 dv=1",
               overflow, act_status(), dout, dout_valid, exp_status(8));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 1'b1);
      checks++;
      if (dout !== exp_rd[i] || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL simul_full_read_%0d dout=%0d dv=%b required dout=%0d dv=1",
                 i, dout, dout_valid, exp_rd[i]);
      end
    end
    cycle(1'b1, 3'd2, 1'b1);
    checks++;
    if (underflow !== 1'b1 || act_status() !== exp_status(1) || dout_valid !== 1'b0 || dout !== 3'd6) begin
      errors++;
      $display("FAIL simul_empty un=%b status=%b dv=%b dout=%0d required un=1 status=%b dv=0 dout=6",
               underflow, act_status(), dout_valid, dout, exp_status(1));
    end
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (dout !== 3'd2 || dout_valid !== 1'b1 || underflow !== 1'b0 || act_status() !== exp_status(0)) begin
      errors++;
      $display("FAIL simul_empty_read dout=%0d dv=%b un=%b status=%b required dout=2 dv=1 un=0 status=%b",
               dout, dout_valid, underflow, act_status(), exp_status(0));
    end
    cycle(1'b1, 3'd3, 1'b0);
    cycle(1'b1, 3'd4, 1'b0);
    cycle(1'b1, 3'd5, 1'b1);
    checks++;
    if (dout !== 3'd3 || dout_valid !== 1'b1 || act_status() !== exp_status(2)) begin
      errors++;
      $display("FAIL simul_mid dout=%0d dv=%b status=%b required dout=3 dv=1 status=%b",
               dout, dout_valid, act_status(), exp_status(2));
    end
    cycle(1'b0, 3'd0, 1'b1);
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (dout !== 3'd5 || act_status() !== exp_status(0)) begin
      errors++;
      $display("FAIL simul_mid_drain dout=%0d status=%b required dout=5 status=%b",
               dout, act_status(), exp_status(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    wr_signal = 1'b0;
    rd_signal = 1'b0;
    din       = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_param_fifo
